fft_agu_seq: RTL and testbench

- Self-sequencing radix-2 in-place FFT address generator.
- On a start pulse, walks every stage and butterfly pair of a runtime-selected transform size up to N_MAX and emits one registered beat per pair: two data addresses plus a twiddle address.
- Output uses a valid/ready handshake with stall.
- Sits between the FFT controller (start/done) and the sample-RAM/twiddle-ROM read ports.

---
 rtl/fft_agu_seq.sv | 193 +++++++++++++++++++
 tb/tb_fft_agu_seq.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/fft_agu_seq.sv
// Radix-2 in-place FFT address generator: one registered beat per butterfly pair, valid/ready out.
// FFT_AGU_BITREV_LOAD_EN adds a bit-reversed load pass ahead of the butterfly stages.
module fft_agu_seq #(
  parameter int N_MAX   = 32,
  parameter int LOG2N_W = $clog2($clog2(N_MAX)) + 1,
  parameter int ADDR_W  = $clog2(N_MAX),
  parameter int PAIR_W  = ADDR_W - 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [LOG2N_W-1:0] cfg_log2n,
  output logic               busy,
  output logic               done,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [ADDR_W-1:0]  address1,
  output logic [ADDR_W-1:0]  address2,
  output logic [PAIR_W-1:0]  twiddle_address,
  output logic [LOG2N_W-1:0] stage,
  output logic [PAIR_W-1:0]  pair_id,
  output logic               last,
  output logic               load_phase
);

  localparam logic [LOG2N_W-1:0] N_LO = LOG2N_W'(2);
  localparam logic [LOG2N_W-1:0] N_HI = LOG2N_W'(ADDR_W);

`ifdef FFT_AGU_BITREV_LOAD_EN
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE, S_LOAD} state_e;
`else
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_e;
`endif

  typedef struct packed {
    logic [ADDR_W-1:0]  a1;
    logic [ADDR_W-1:0]  a2;
    logic [PAIR_W-1:0]  tw;
    logic [LOG2N_W-1:0] stage;
    logic [PAIR_W-1:0]  pair;
    logic               last;
    logic               load;
  } beat_t;

  function automatic logic [LOG2N_W-1:0] clamp_n(input logic [LOG2N_W-1:0] cfg);
    if (cfg < N_LO) return N_LO;
    if (cfg > N_HI) return N_HI;
    return cfg;
  endfunction

  function automatic logic [PAIR_W-1:0] pair_max(input logic [LOG2N_W-1:0] n);
    return ~({PAIR_W{1'b1}} << (n - LOG2N_W'(1)));
  endfunction

  // Rotate within the low n bits: bits shifted past n wrap back to the bottom.
  function automatic logic [ADDR_W-1:0] rotl_n(input logic [ADDR_W-1:0] x,
                                               input logic [LOG2N_W-1:0] s,
                                               input logic [LOG2N_W-1:0] n);
    logic [2*ADDR_W-1:0] xs;
    logic [ADDR_W-1:0]   mask;
    xs   = {{ADDR_W{1'b0}}, x} << s;
    xs   = xs | (xs >> n);
    mask = ~({ADDR_W{1'b1}} << n);
    return xs[ADDR_W-1:0] & mask;
  endfunction

  // Full-width reverse, then drop the ADDR_W-n zero bits that land at the bottom.
  function automatic logic [ADDR_W-1:0] bitrev_n(input logic [ADDR_W-1:0] x,
                                                 input logic [LOG2N_W-1:0] n);
    logic [ADDR_W-1:0] r;
    for (int i = 0; i < ADDR_W; i++) r[i] = x[ADDR_W-1-i];
    return r >> (ADDR_W - int'(n));
  endfunction

  function automatic beat_t make_beat(input logic [LOG2N_W-1:0] n,
                                      input logic [LOG2N_W-1:0] s,
                                      input logic [PAIR_W-1:0]  p,
                                      input logic               ld);
    beat_t             b;
    logic [ADDR_W-1:0] x1;
    logic [ADDR_W-1:0] x2;
    x1      = {p, 1'b0};
    x2      = {p, 1'b1};
    b.stage = s;
    b.pair  = p;
    b.load  = ld;
    if (ld) begin
      b.a1   = bitrev_n(x1, n);
      b.a2   = bitrev_n(x2, n);
      b.tw   = '0;
      b.last = 1'b0;
    end else begin
      b.a1   = rotl_n(x1, s, n);
      b.a2   = rotl_n(x2, s, n);
      b.tw   = p & ~({PAIR_W{1'b1}} << s);
      b.last = (s == n - LOG2N_W'(1)) && (p == pair_max(n));
    end
    return b;
  endfunction

  state_e             state_q, state_d;
  logic [LOG2N_W-1:0] n_q, n_d;
  beat_t              beat_q, beat_d;
  logic               vld_q, vld_d;

  logic               accept;
  logic               pair_wrap;
  logic [LOG2N_W-1:0] nxt_s;
  logic [PAIR_W-1:0]  nxt_p;
  logic [LOG2N_W-1:0] n_start;

  always_comb begin
    state_d   = state_q;
    n_d       = n_q;
    beat_d    = beat_q;
    vld_d     = vld_q;
    accept    = vld_q && out_ready;
    pair_wrap = (beat_q.pair == pair_max(n_q));
    nxt_s     = pair_wrap ? beat_q.stage + LOG2N_W'(1) : beat_q.stage;
    nxt_p     = pair_wrap ? '0 : beat_q.pair + PAIR_W'(1);
    n_start   = clamp_n(cfg_log2n);
    case (state_q)
      S_IDLE: begin
        if (start) begin
          n_d   = n_start;
          vld_d = 1'b1;
`ifdef FFT_AGU_BITREV_LOAD_EN
          state_d = S_LOAD;
          beat_d  = make_beat(n_start, '0, '0, 1'b1);
`else
          state_d = S_RUN;
          beat_d  = make_beat(n_start, '0, '0, 1'b0);
`endif
        end
      end
`ifdef FFT_AGU_BITREV_LOAD_EN
      S_LOAD: begin
        if (accept) begin
          if (pair_wrap) begin
            state_d = S_RUN;
            beat_d  = make_beat(n_q, '0, '0, 1'b0);
          end else begin
            beat_d  = make_beat(n_q, '0, nxt_p, 1'b1);
          end
        end
      end
`endif
      S_RUN: begin
        if (accept) begin
          if (beat_q.last) begin
            state_d = S_DONE;
            vld_d   = 1'b0;
            beat_d  = '0;
          end else begin
            beat_d  = make_beat(n_q, nxt_s, nxt_p, 1'b0);
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      n_q     <= '0;
      beat_q  <= '0;
      vld_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      n_q     <= n_d;
      beat_q  <= beat_d;
      vld_q   <= vld_d;
    end
  end

`ifdef FFT_AGU_BITREV_LOAD_EN
  assign busy = (state_q == S_RUN) || (state_q == S_LOAD);
`else
  assign busy = (state_q == S_RUN);
`endif
  assign done            = (state_q == S_DONE);
  assign out_valid       = vld_q;
  assign address1        = beat_q.a1;
  assign address2        = beat_q.a2;
  assign twiddle_address = beat_q.tw;
  assign stage           = beat_q.stage;
  assign pair_id         = beat_q.pair;
  assign last            = beat_q.last;
  assign load_phase      = beat_q.load;

endmodule

// File: tb/tb_fft_agu_seq.sv
// Directed bench for fft_agu_seq: hand-computed beat tables for n=2/3, structural checks for n=5.
module tb_fft_agu_seq;
  localparam int N_MAX = 32, LOG2N_W = 4, ADDR_W = 5, PAIR_W = 4;
`ifdef FFT_AGU_BITREV_LOAD_EN
  localparam int LD = 1;
`else
  localparam int LD = 0;
`endif

  logic clk = 1'b0, reset = 1'b1, start = 1'b0, out_ready = 1'b0;
  logic [LOG2N_W-1:0] cfg_log2n = '0;
  logic busy, done, out_valid, last, load_phase;
  logic [ADDR_W-1:0] address1, address2;
  logic [PAIR_W-1:0] twiddle_address, pair_id;
  logic [LOG2N_W-1:0] stage;

  fft_agu_seq #(.N_MAX(N_MAX)) dut (
    .clk(clk), .reset(reset), .start(start), .cfg_log2n(cfg_log2n),
    .busy(busy), .done(done), .out_valid(out_valid), .out_ready(out_ready),
    .address1(address1), .address2(address2), .twiddle_address(twiddle_address),
    .stage(stage), .pair_id(pair_id), .last(last), .load_phase(load_phase)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_fail = 0;
  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // {a1, a2, tw, stage, pair, last, load}
  logic [23:0] cur;
  assign cur = {address1, address2, twiddle_address, stage, pair_id, last, load_phase};

  localparam int R3_A1[12] = '{0, 2, 4, 6, 0, 4, 1, 5, 0, 1, 2, 3};
  localparam int R3_A2[12] = '{1, 3, 5, 7, 2, 6, 3, 7, 4, 5, 6, 7};
  localparam int R3_TW[12] = '{0, 0, 0, 0, 0, 1, 0, 1, 0, 1, 2, 3};
  localparam int L3_A1[4]  = '{0, 2, 1, 3};
  localparam int L3_A2[4]  = '{4, 6, 5, 7};
  localparam int R2_A1[4]  = '{0, 2, 0, 1};
  localparam int R2_A2[4]  = '{1, 3, 2, 3};
  localparam int R2_TW[4]  = '{0, 0, 0, 1};
  localparam int L2_A1[2]  = '{0, 1};
  localparam int L2_A2[2]  = '{2, 3};

  function automatic logic [23:0] mk(int a1, int a2, int tw, int st, int pr, bit lst, bit ld);
    return {5'(a1), 5'(a2), 4'(tw), 4'(st), 4'(pr), lst, ld};
  endfunction

  function automatic logic [23:0] exp_small(int n, int i);
    int p, j;
    p = 1 << (n - 1);
    if (i < LD * p)
      return (n == 3) ? mk(L3_A1[i], L3_A2[i], 0, 0, i, 0, 1) : mk(L2_A1[i], L2_A2[i], 0, 0, i, 0, 1);
    j = i - LD * p;
    if (n == 3) return mk(R3_A1[j], R3_A2[j], R3_TW[j], j / p, j % p, j == 11, 0);
    return mk(R2_A1[j], R2_A2[j], R2_TW[j], j / p, j % p, j == 3, 0);
  endfunction

  logic [23:0] g_vec[256];
  int nb, bubbles;

  task automatic do_start(input logic [LOG2N_W-1:0] cfg);
    cfg_log2n = cfg;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("lat_valid", 32'(out_valid), 1);
    chk("lat_busy", 32'(busy), 1);
  endtask

  task automatic collect(input bit rnd, input int budget);
    bit stall, done_seen;
    logic [24:0] sv;
    nb = 0; bubbles = 0; stall = 0; done_seen = 0; sv = '0;
    for (int c = 0; c < budget; c++) begin
      if (stall) chk("stall_hold", 32'({out_valid, cur}), 32'(sv));
      if (done) begin done_seen = 1; break; end
      out_ready = rnd ? ($urandom_range(0, 1) == 1) : 1'b1;
      if (out_valid && out_ready && nb < 256) begin g_vec[nb] = cur; nb++; end
      if (!out_valid) bubbles++;
      stall = out_valid && !out_ready;
      sv = {out_valid, cur};
      @(posedge clk); #1;
    end
    chk("done_seen", 32'(done_seen), 1);
    if (done_seen) begin
      chk("done_busy_low", 32'(busy), 0);
      @(posedge clk); #1;
      chk("done_one_cycle", 32'({done, busy}), 0);
    end
  endtask

  task automatic check_small(input string tag, input int n);
    int tot;
    tot = (n + LD) * (1 << (n - 1));
    chk({tag, "_count"}, 32'(nb), 32'(tot));
    for (int i = 0; i < nb && i < tot; i++) chk({tag, "_beat"}, 32'(g_vec[i]), 32'(exp_small(n, i)));
  endtask

  task automatic check_big(input string tag);
    logic [31:0] cov[5];
    int tot, dup, j, s, p;
    logic [4:0] a1, a2;
    logic [3:0] tw, st, pr;
    logic lst, ld;
    tot = (5 + LD) * 16; dup = 0;
    for (int k = 0; k < 5; k++) cov[k] = '0;
    chk({tag, "_count"}, 32'(nb), 32'(tot));
    for (int i = 0; i < nb && i < tot; i++) begin
      {a1, a2, tw, st, pr, lst, ld} = g_vec[i];
      if (i < LD * 16) begin
        chk({tag, "_load_side"}, 32'({tw, st, pr, lst, ld}), 32'({4'd0, 4'd0, 4'(i), 1'b0, 1'b1}));
      end else begin
        j = i - LD * 16; s = j / 16; p = j % 16;
        chk({tag, "_seq"}, 32'({st, pr, lst, ld}), 32'({4'(s), 4'(p), j == 79, 1'b0}));
        chk({tag, "_a2_rel"}, 32'(a2), 32'(a1) | (32'd1 << s));
        chk({tag, "_tw"}, 32'(tw), 32'(p & ((1 << s) - 1)));
        if (j == 17) chk({tag, "_s1p1"}, 32'({a1, a2, tw}), 32'({5'd4, 5'd6, 4'd1}));
        if (j == 79) chk({tag, "_s4p15"}, 32'({a1, a2, tw}), 32'({5'd15, 5'd31, 4'd15}));
        if (cov[s][a1] || cov[s][a2]) dup++;
        cov[s][a1] = 1'b1;
        cov[s][a2] = 1'b1;
      end
    end
    for (int k = 0; k < 5; k++) chk({tag, "_cover"}, cov[k], 32'hffff_ffff);
    chk({tag, "_dup"}, 32'(dup), 0);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    chk("rst_outputs", 32'({cur, out_valid, busy, done}), 0);

    // n=3, ready held high; cfg changed after start must not matter
    do_start(4'd3);
    cfg_log2n = 4'd0;
    collect(0, 100);
    check_small("n3", 3);
    chk("n3_bubbles", 32'(bubbles), 0);

    // n=5 with random backpressure
    do_start(4'd5);
    collect(1, 2000);
    check_big("n5");

    // clamping
    do_start(4'd0);
    collect(0, 100);
    check_small("clamp_lo", 2);
    do_start(4'd7);
    collect(1, 2000);
    check_big("clamp_hi");

    // start ignored mid-run, then reset at beat 5
    do_start(4'd3);
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      chk("mid_beat", 32'({out_valid, cur}), 32'({1'b1, exp_small(3, i)}));
      start = (i == 1);
      cfg_log2n = 4'd2;
      @(posedge clk); #1;
    end
    start = 1'b0;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    out_ready = 1'b0;
    chk("mid_rst_outputs", 32'({cur, out_valid, busy, done}), 0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("mid_rst_no_done", 32'({done, busy, out_valid}), 0);
    end
    do_start(4'd3);
    collect(0, 100);
    check_small("restart", 3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
